// File: rtl/shared_reg_arbiter_if.sv
// shared_reg_arbiter_if: request/data inputs and shared register outputs.
// master drives req/data_in; slave (the arbiter) drives the rest.
interface shared_reg_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data_in;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      out;
  logic                  upd;
  logic                  out_valid;
  logic [IW-1:0]         owner;

  modport master (
    output req,
    output data_in,
    input  gnt,
    input  out,
    input  upd,
    input  out_valid,
    input  owner
  );

  modport slave (
    input  req,
    input  data_in,
    output gnt,
    output out,
    output upd,
    output out_valid,
    output owner
  );
endinterface

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin writer of one shared WIDTH-bit register.
// Ports: clk, rst_n (async low), bus.slave (req/data_in in; gnt/out/upd/out_valid/owner out).
module shared_reg_arbiter #(
  parameter int WIDTH       = 4,
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  shared_reg_arbiter_if.slave  bus
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

  localparam logic [IW-1:0]   LAST_RST = IW'(NREQ - 1);
  localparam logic [CW-1:0]   HOLD_LD  = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [NREQ-1:0] GNT_ONE  = NREQ'(1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HOLD
  } state_e;

  state_e state_q, state_d;

  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             upd_q, upd_d;
  logic             valid_q, valid_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    last_q, last_d;
  logic [IW-1:0]    win_q, win_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] words [NREQ];
  logic [WIDTH-1:0] win_word;
  logic [IW-1:0]    pick;
  logic             found;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      words[i] = bus.data_in[i*WIDTH +: WIDTH];
    end
  end

  assign win_word = words[win_q];

  // Scan from last+1 upward; explicit wrap keeps non-power-of-two
  // NREQ from indexing past the top requester.
  always_comb begin
    int idx;
    idx   = 0;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    out_d   = out_q;
    upd_d   = 1'b0;
    valid_d = valid_q;
    owner_d = owner_q;
    last_d  = last_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = LOAD;
          win_d   = pick;
          gnt_d   = GNT_ONE << pick;
        end
      end
      LOAD: begin
        // Dropped request aborts without touching last, so the
        // same requester stays first in line.
        state_d = IDLE;
        if (bus.req[win_q]) begin
          out_d   = win_word;
          owner_d = win_q;
          last_d  = win_q;
          valid_d = 1'b1;
          upd_d   = 1'b1;
          if (HOLD_CYCLES > 0) begin
            state_d = HOLD;
            cnt_d   = HOLD_LD;
          end
        end
      end
      HOLD: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      out_q   <= '0;
      upd_q   <= 1'b0;
      valid_q <= 1'b0;
      owner_q <= '0;
      last_q  <= LAST_RST;
      win_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      out_q   <= out_d;
      upd_q   <= upd_d;
      valid_q <= valid_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.out       = out_q;
  assign bus.upd       = upd_q;
  assign bus.out_valid = valid_q;
  assign bus.owner     = owner_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter: scoreboard bench for two builds (HOLD 2 and HOLD 0).
// Model predicts grant/update events by edge number; monitor pops and compares.
module tb_shared_reg_arbiter;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  shared_reg_arbiter_if #(.WIDTH(4), .NREQ(4)) bus0 ();
  shared_reg_arbiter_if #(.WIDTH(4), .NREQ(4)) bus1 ();

  shared_reg_arbiter #(
    .WIDTH(4), .NREQ(4), .HOLD_CYCLES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );

  shared_reg_arbiter #(
    .WIDTH(4), .NREQ(4), .HOLD_CYCLES(0)
  ) dut_h0 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  typedef struct {
    int         e;
    logic [3:0] gnt;
  } gev_t;

  typedef struct {
    int         e;
    logic [3:0] out;
    int         owner;
  } uev_t;

  gev_t gq [2][$];
  uev_t uq [2][$];

  int checks = 0;
  int errors = 0;

  int edge_n = 0;
  int last_w   [2] = '{3, 3};
  int next_arb [2] = '{0, 0};
  int pend     [2] = '{0, 0};
  int pw       [2] = '{0, 0};

  logic [3:0] prev_out [2] = '{4'h0, 4'h0};
  logic       prev_upd [2] = '{1'b0, 1'b0};

  function automatic int hold_of(int m);
    return (m == 0) ? 2 : 0;
  endfunction

  task automatic chk(string name, int m, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s [dut%0d] at edge %0d: actual %0h, required %0h",
               name, m, edge_n, act, exp);
    end
  endtask

  function automatic int rr_pick(logic [3:0] r, int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_step(int m);
    logic [3:0]  r;
    logic [15:0] d;
    gev_t        g;
    uev_t        u;
    int          w;
    r = bus0.req;
    d = bus0.data_in;
    if (pend[m] != 0) begin
      pend[m] = 0;
      if (r[pw[m]]) begin
        u.e     = edge_n;
        u.out   = d[pw[m]*4 +: 4];
        u.owner = pw[m];
        uq[m].push_back(u);
        last_w[m]   = pw[m];
        next_arb[m] = edge_n + 1 + hold_of(m);
      end else begin
        next_arb[m] = edge_n + 1;
      end
    end else if (edge_n >= next_arb[m] && r != 4'b0) begin
      w     = rr_pick(r, last_w[m]);
      g.e   = edge_n;
      g.gnt = 4'b0001 << w;
      gq[m].push_back(g);
      pend[m] = 1;
      pw[m]   = w;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      edge_n = 0;
      for (int m = 0; m < 2; m++) begin
        last_w[m]   = 3;
        next_arb[m] = 0;
        pend[m]     = 0;
        gq[m].delete();
        uq[m].delete();
      end
    end else begin
      edge_n++;
      for (int m = 0; m < 2; m++) model_step(m);
    end
  end

  task automatic mon(int m, logic [3:0] g, logic u, logic [3:0] o,
                     logic [1:0] own, logic v);
    gev_t ge;
    uev_t ue;
    if (g != 4'b0) begin
      chk("gnt_onehot", m, $countones(g), 1);
      if (gq[m].size() == 0) begin
        chk("gnt_unexpected", m, int'(g), 0);
      end else begin
        ge = gq[m].pop_front();
        chk("gnt_edge", m, edge_n, ge.e);
        chk("gnt_value", m, int'(g), int'(ge.gnt));
      end
    end else if (gq[m].size() > 0 && gq[m][0].e <= edge_n) begin
      ge = gq[m].pop_front();
      chk("gnt_missing", m, 0, int'(ge.gnt));
    end
    if (u) begin
      chk("upd_adjacent", m, int'(prev_upd[m]), 0);
      chk("out_valid", m, int'(v), 1);
      if (uq[m].size() == 0) begin
        chk("upd_unexpected", m, 1, 0);
      end else begin
        ue = uq[m].pop_front();
        chk("upd_edge", m, edge_n, ue.e);
        chk("out_value", m, int'(o), int'(ue.out));
        chk("owner", m, int'(own), ue.owner);
      end
    end else begin
      if (uq[m].size() > 0 && uq[m][0].e <= edge_n) begin
        ue = uq[m].pop_front();
        chk("upd_missing", m, 0, 1);
      end
      if (o != prev_out[m]) chk("out_changed_without_upd", m, int'(o), int'(prev_out[m]));
    end
    prev_out[m] = o;
    prev_upd[m] = u;
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_out = '{4'h0, 4'h0};
      prev_upd = '{1'b0, 1'b0};
    end else begin
      mon(0, bus0.gnt, bus0.upd, bus0.out, bus0.owner, bus0.out_valid);
      mon(1, bus1.gnt, bus1.upd, bus1.out, bus1.owner, bus1.out_valid);
    end
  end

  task automatic drive(logic [3:0] r, logic [15:0] d);
    bus0.req     = r;
    bus1.req     = r;
    bus0.data_in = d;
    bus1.data_in = d;
  endtask

  task automatic reset_checks(string tag);
    #1;
    chk({tag, "_gnt"}, 0, int'(bus0.gnt), 0);
    chk({tag, "_out"}, 0, int'(bus0.out), 0);
    chk({tag, "_upd"}, 0, int'(bus0.upd), 0);
    chk({tag, "_valid"}, 0, int'(bus0.out_valid), 0);
    chk({tag, "_owner"}, 0, int'(bus0.owner), 0);
    chk({tag, "_gnt"}, 1, int'(bus1.gnt), 0);
    chk({tag, "_out"}, 1, int'(bus1.out), 0);
    chk({tag, "_upd"}, 1, int'(bus1.upd), 0);
    chk({tag, "_valid"}, 1, int'(bus1.out_valid), 0);
    chk({tag, "_owner"}, 1, int'(bus1.owner), 0);
  endtask

  task automatic idle_cycles(int n, logic [3:0] r, logic [15:0] d);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive(r, d);
    end
  endtask

  initial begin
    logic [3:0] r;
    rst_n = 1'b0;
    drive(4'b1111, 16'h4321);
    reset_checks("rst_initial");
    repeat (3) @(posedge clk);
    reset_checks("rst_held");
    @(negedge clk);
    drive(4'b0000, 16'h0);
    #1 rst_n = 1'b1;

    idle_cycles(2, 4'b0000, 16'h0);
    idle_cycles(12, 4'b0010, 16'h00A0);
    idle_cycles(6, 4'b0000, 16'h0);

    idle_cycles(30, 4'b1111, 16'h4321);
    idle_cycles(6, 4'b0000, 16'h0);

    idle_cycles(1, 4'b0100, 16'h0900);
    idle_cycles(1, 4'b0000, 16'h0900);
    idle_cycles(2, 4'b0000, 16'h0);
    idle_cycles(12, 4'b0101, 16'h0B0C);
    idle_cycles(6, 4'b0000, 16'h0);

    @(negedge clk);
    drive(4'b1000, 16'h7000);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("pre_rst_out", 0, int'(bus0.out), 7);
    chk("pre_rst_out", 1, int'(bus1.out), 7);
    #1 rst_n = 1'b0;
    reset_checks("rst_mid_hold");
    @(negedge clk);
    drive(4'b1001, 16'h7005);
    #1 rst_n = 1'b1;
    idle_cycles(12, 4'b1001, 16'h7005);

    r = 4'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 2) == 0) r = 4'($urandom);
      drive(r, 16'($urandom));
      if ($urandom_range(0, 399) == 0) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        reset_checks("rst_random");
        @(negedge clk);
        #1 rst_n = 1'b1;
      end
    end

    idle_cycles(20, 4'b0000, 16'h0);
    for (int m = 0; m < 2; m++) begin
      chk("gnt_queue_drained", m, gq[m].size(), 0);
      chk("upd_queue_drained", m, uq[m].size(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
